// File: rtl/riscv_lsu_ctrl_pkg.sv
// Shared types and encodings for the LW/SW load-store control slice.
// Holds opcodes, the memory transaction layout, FSM states and error codes.
package riscv_lsu_ctrl_pkg;

    localparam logic [6:0] LOAD_OPCODE  = 7'b0000011;
    localparam logic [6:0] STORE_OPCODE = 7'b0100011;
    localparam logic [2:0] LW_FUNCT3    = 3'b010;
    localparam logic [2:0] SW_FUNCT3    = 3'b010;
    localparam logic [2:0] SIZE_WORD    = 3'b010;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic        is_load;
        logic [2:0]  size;
    } mem_transaction_t;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        REQ,
        WAIT_RSP,
        WB,
        ERR
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_ILLEGAL  = 2'b01,
        ERR_MISALIGN = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_t;

    typedef struct packed {
        logic        is_load;
        logic        legal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm32;
    } decoded_mem_instr_t;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/riscv_lsu_ctrl_if.sv
// Instruction and data-memory handshake bundle of the load-store controller.
// master = the controller itself; slave = instruction source plus memory responder.
interface riscv_lsu_ctrl_if;
    import riscv_lsu_ctrl_pkg::*;

    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic             mem_req_valid;
    logic             mem_req_ready;
    mem_transaction_t mem_req;
    logic             mem_rsp_valid;
    logic [31:0]      mem_rsp_data;

    modport master (
        input  instr_valid, instr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output instr_ready, mem_req_valid, mem_req
    );

    modport slave (
        output instr_valid, instr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  instr_ready, mem_req_valid, mem_req
    );

endinterface

// File: rtl/riscv_lsu_ctrl_decode.sv
// Combinational LW/SW decoder: raw instruction word to decoded_mem_instr_t.
module riscv_mem_instr_decode
    import riscv_lsu_ctrl_pkg::*;
(
    input  logic [31:0]        instr,
    output decoded_mem_instr_t dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        dec         = '0;
        dec.is_load = (opcode == LOAD_OPCODE);
        dec.legal   = ((opcode == LOAD_OPCODE)  && (funct3 == LW_FUNCT3)) ||
                      ((opcode == STORE_OPCODE) && (funct3 == SW_FUNCT3));
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        // Loads carry the immediate in [31:20]; stores split it around rd's field.
        dec.imm32   = dec.is_load ? sext12(instr[31:20])
                                  : sext12({instr[31:25], instr[11:7]});
    end

endmodule

// File: rtl/riscv_lsu_ctrl.sv
// LW/SW load-store controller: decodes one instruction at a time, issues a word
// request to data memory and writes load data back to the register file.
module riscv_lsu_ctrl
    import riscv_lsu_ctrl_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = 256,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    riscv_lsu_ctrl_if.master     bus,
    output logic [4:0]           rf_rs1_idx,
    output logic [4:0]           rf_rs2_idx,
    input  logic [31:0]          rf_rs1_data,
    input  logic [31:0]          rf_rs2_data,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd,
    output logic [31:0]          wb_data,
    output logic                 err_valid,
    output logic [1:0]           err_code,
    output logic                 busy
);

    lsu_state_t         state_q, state_d;
    logic [31:0]        instr_q;
    decoded_mem_instr_t dec;
    logic [31:0]        addr;
    logic               misaligned;
    logic               tmo_hit;
    mem_transaction_t   req_q;
    logic [31:0]        rsp_q;
    lsu_err_t           err_q;
    logic [31:0]        tmo_q;

    riscv_mem_instr_decode u_decode (
        .instr (instr_q),
        .dec   (dec)
    );

    assign rf_rs1_idx = instr_q[19:15];
    assign rf_rs2_idx = instr_q[24:20];
    assign addr       = rf_rs1_data + dec.imm32;
    assign misaligned = CHECK_ALIGN && (addr[1:0] != 2'b00);
    // tmo_q holds cycles already spent waiting; abort once this cycle makes RSP_TIMEOUT.
    assign tmo_hit    = (RSP_TIMEOUT != 0) && (tmo_q == 32'(RSP_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        bus.instr_ready   = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_req       = req_q;
        wb_valid          = 1'b0;
        wb_rd             = '0;
        wb_data           = '0;
        err_valid         = 1'b0;
        err_code          = '0;
        busy              = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                bus.instr_ready = !rst;
                if (bus.instr_valid) state_d = EXEC;
            end
            EXEC: begin
                if (!dec.legal || misaligned) state_d = ERR;
                else                          state_d = REQ;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                if (bus.mem_req_ready) state_d = req_q.is_load ? WAIT_RSP : IDLE;
            end
            WAIT_RSP: begin
                if (bus.mem_rsp_valid) state_d = WB;
                else if (tmo_hit)      state_d = ERR;
            end
            WB: begin
                wb_valid = (dec.rd != 5'd0);
                wb_rd    = wb_valid ? dec.rd : '0;
                wb_data  = wb_valid ? rsp_q  : '0;
                state_d  = IDLE;
            end
            ERR: begin
                err_valid = 1'b1;
                err_code  = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            req_q   <= '0;
            rsp_q   <= '0;
            err_q   <= ERR_NONE;
            tmo_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.instr_valid) instr_q <= bus.instr;
                EXEC: begin
                    if (!dec.legal)      err_q <= ERR_ILLEGAL;
                    else if (misaligned) err_q <= ERR_MISALIGN;
                    else begin
                        req_q.address <= addr;
                        req_q.data    <= dec.is_load ? '0 : rf_rs2_data;
                        req_q.is_load <= dec.is_load;
                        req_q.size    <= SIZE_WORD;
                    end
                end
                REQ: tmo_q <= '0;
                WAIT_RSP: begin
                    tmo_q <= tmo_q + 32'd1;
                    if (bus.mem_rsp_valid) rsp_q <= bus.mem_rsp_data;
                    else if (tmo_hit)      err_q <= ERR_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// Scoreboard bench for riscv_lsu_ctrl: directed LW/SW vectors push expected
// requests, write-backs and errors; negedge monitors pop and compare.
module tb_riscv_lsu_ctrl;
    import riscv_lsu_ctrl_pkg::*;

    localparam int K_REQ = 0;
    localparam int K_WB  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [67:0] req;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  code;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] regs [32];

    // DUT A: alignment checked, short timeout.
    riscv_lsu_ctrl_if ifa ();
    logic [4:0]  a_rs1_idx, a_rs2_idx;
    logic [31:0] a_rs1_data, a_rs2_data, a_wb_data;
    logic        a_wb_valid, a_err_valid, a_busy;
    logic [4:0]  a_wb_rd;
    logic [1:0]  a_err_code;
    assign a_rs1_data = regs[a_rs1_idx];
    assign a_rs2_data = regs[a_rs2_idx];

    riscv_lsu_ctrl #(.RSP_TIMEOUT(8), .CHECK_ALIGN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa),
        .rf_rs1_idx(a_rs1_idx), .rf_rs2_idx(a_rs2_idx),
        .rf_rs1_data(a_rs1_data), .rf_rs2_data(a_rs2_data),
        .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
        .err_valid(a_err_valid), .err_code(a_err_code), .busy(a_busy)
    );

    // DUT B: alignment check disabled.
    riscv_lsu_ctrl_if ifb ();
    logic [4:0]  b_rs1_idx, b_rs2_idx;
    logic [31:0] b_rs1_data, b_rs2_data, b_wb_data;
    logic        b_wb_valid, b_err_valid, b_busy;
    logic [4:0]  b_wb_rd;
    logic [1:0]  b_err_code;
    assign b_rs1_data = regs[b_rs1_idx];
    assign b_rs2_data = regs[b_rs2_idx];

    riscv_lsu_ctrl #(.RSP_TIMEOUT(256), .CHECK_ALIGN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb),
        .rf_rs1_idx(b_rs1_idx), .rf_rs2_idx(b_rs2_idx),
        .rf_rs1_data(b_rs1_data), .rf_rs2_data(b_rs2_data),
        .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
        .err_valid(b_err_valid), .err_code(b_err_code), .busy(b_busy)
    );

    exp_t exp_a[$];
    exp_t exp_b[$];

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [31:0] gen_sw_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                                 input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] gen_lw_instr(input logic [4:0] rd, input logic [4:0] rs1,
                                                 input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic exp_t mk(input int kind, input logic [67:0] req, input logic [4:0] rd,
                                input logic [31:0] data, input logic [1:0] code);
        exp_t e;
        e.kind = kind; e.req = req; e.rd = rd; e.data = data; e.code = code;
        return e;
    endfunction

    // Monitor A
    logic        pv_a = 1'b0, pr_a = 1'b0;
    logic [67:0] preq_a = '0;
    exp_t        ea;
    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.mem_req_valid && pv_a && !pr_a) check("req_stable", ifa.mem_req, preq_a);
            if (ifa.mem_req_valid && ifa.mem_req_ready) begin
                if (exp_a.size() == 0) fail_now("unexpected_req");
                else begin
                    ea = exp_a.pop_front();
                    check("req_kind", 68'(ea.kind), 68'(K_REQ));
                    check("req", ifa.mem_req, ea.req);
                end
            end
            if (a_wb_valid) begin
                if (exp_a.size() == 0) fail_now("unexpected_wb");
                else begin
                    ea = exp_a.pop_front();
                    check("wb_kind", 68'(ea.kind), 68'(K_WB));
                    check("wb_rd", 68'(a_wb_rd), 68'(ea.rd));
                    check("wb_data", 68'(a_wb_data), 68'(ea.data));
                end
            end
            if (a_err_valid) begin
                if (exp_a.size() == 0) fail_now("unexpected_err");
                else begin
                    ea = exp_a.pop_front();
                    check("err_kind", 68'(ea.kind), 68'(K_ERR));
                    check("err_code", 68'(a_err_code), 68'(ea.code));
                end
            end
        end
        pv_a   <= ifa.mem_req_valid;
        pr_a   <= ifa.mem_req_ready;
        preq_a <= ifa.mem_req;
    end

    // Monitor B
    exp_t eb;
    always @(negedge clk) begin
        if (!rst) begin
            if (ifb.mem_req_valid && ifb.mem_req_ready) begin
                if (exp_b.size() == 0) fail_now("b_unexpected_req");
                else begin
                    eb = exp_b.pop_front();
                    check("b_req", ifb.mem_req, eb.req);
                end
            end
            if (b_wb_valid)  fail_now("b_unexpected_wb");
            if (b_err_valid) fail_now("b_unexpected_err");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond_a(input int what);
        case (what)
            0:       return ifa.mem_req_valid;
            1:       return a_err_valid;
            default: return ifa.instr_ready && !a_busy;
        endcase
    endfunction

    task automatic wait_a(input int what, input string name);
        int unsigned n = 0;
        while (!cond_a(what) && n < 60) begin
            tick();
            n++;
        end
        if (!cond_a(what)) fail_now(name);
    endtask

    task automatic issue_a(input logic [31:0] ins);
        wait_a(2, "issue_wait");
        ifa.instr       = ins;
        ifa.instr_valid = 1'b1;
        tick();
        ifa.instr_valid = 1'b0;
    endtask

    task automatic respond_a(input logic [31:0] d);
        ifa.mem_rsp_valid = 1'b1;
        ifa.mem_rsp_data  = d;
        tick();
        ifa.mem_rsp_valid = 1'b0;
        ifa.mem_rsp_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;
        regs[1] = 32'h0000_0200;
        regs[2] = 32'h0000_0100;
        regs[5] = 32'hDEAD_BEEF;
        regs[6] = 32'h0000_0101;
        regs[7] = 32'hFFFF_FFFC;
        ifa.instr_valid = 1'b0; ifa.instr = '0; ifa.mem_req_ready = 1'b1;
        ifa.mem_rsp_valid = 1'b0; ifa.mem_rsp_data = '0;
        ifb.instr_valid = 1'b0; ifb.instr = '0; ifb.mem_req_ready = 1'b1;
        ifb.mem_rsp_valid = 1'b0; ifb.mem_rsp_data = '0;

        // Reset state
        repeat (3) tick();
        check("rst_ready", 68'(ifa.instr_ready), 68'd0);
        check("rst_busy", 68'(a_busy), 68'd0);
        check("rst_req_valid", 68'(ifa.mem_req_valid), 68'd0);
        check("rst_req", ifa.mem_req, 68'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 68'(ifa.instr_ready), 68'd1);

        // Store: 0x100 + 8, latency to request and back to idle
        exp_a.push_back(mk(K_REQ, {32'h0000_0108, 32'hDEAD_BEEF, 1'b0, 3'b010}, '0, '0, '0));
        issue_a(gen_sw_instr(5'd2, 5'd5, 12'h008));
        check("st_cycle1_no_req", 68'(ifa.mem_req_valid), 68'd0);
        tick();
        check("st_cycle2_req", 68'(ifa.mem_req_valid), 68'd1);
        tick();
        check("st_cycle3_ready", 68'(ifa.instr_ready), 68'd1);

        // Load: 0x200 - 4, response after 4 cycles, write-back one cycle later
        exp_a.push_back(mk(K_REQ, {32'h0000_01FC, 32'h0, 1'b1, 3'b010}, '0, '0, '0));
        exp_a.push_back(mk(K_WB, '0, 5'd3, 32'hCAFE_F00D, '0));
        issue_a(gen_lw_instr(5'd3, 5'd1, 12'hFFC));
        wait_a(0, "ld_req_wait");
        repeat (4) tick();
        respond_a(32'hCAFE_F00D);
        check("ld_wb_latency", 68'(a_wb_valid), 68'd1);
        wait_a(2, "ld_idle");

        // Misaligned load: base 0x101
        exp_a.push_back(mk(K_ERR, '0, '0, '0, 2'b10));
        issue_a(gen_lw_instr(5'd4, 5'd6, 12'h000));
        wait_a(1, "mis_err_wait");
        tick();
        check("mis_ready_next", 68'(ifa.instr_ready), 68'd1);

        // Illegal: R-type opcode, then LB (funct3 000)
        exp_a.push_back(mk(K_ERR, '0, '0, '0, 2'b01));
        issue_a(32'h0020_8033);
        wait_a(1, "ill_err_wait");
        tick();
        check("ill_ready_next", 68'(ifa.instr_ready), 68'd1);
        exp_a.push_back(mk(K_ERR, '0, '0, '0, 2'b01));
        issue_a({12'h000, 5'd1, 3'b000, 5'd3, 7'b0000011});
        wait_a(1, "lb_err_wait");
        tick();
        check("lb_ready_next", 68'(ifa.instr_ready), 68'd1);

        // Backpressure: ready low for 10 cycles, request must hold
        ifa.mem_req_ready = 1'b0;
        exp_a.push_back(mk(K_REQ, {32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 3'b010}, '0, '0, '0));
        issue_a(gen_sw_instr(5'd2, 5'd5, 12'h004));
        wait_a(0, "bp_req_wait");
        repeat (10) tick();
        ifa.mem_req_ready = 1'b1;
        wait_a(2, "bp_idle");

        // Timeout abort, then a late response is ignored
        exp_a.push_back(mk(K_REQ, {32'h0000_0200, 32'h0, 1'b1, 3'b010}, '0, '0, '0));
        exp_a.push_back(mk(K_ERR, '0, '0, '0, 2'b11));
        issue_a(gen_lw_instr(5'd10, 5'd1, 12'h000));
        wait_a(1, "tmo_err_wait");
        tick();
        respond_a(32'h1111_2222);
        check("late_rsp_busy", 68'(a_busy), 68'd0);

        // rd = x0: read performed, no write-back strobe
        exp_a.push_back(mk(K_REQ, {32'h0000_0204, 32'h0, 1'b1, 3'b010}, '0, '0, '0));
        issue_a(gen_lw_instr(5'd0, 5'd1, 12'h004));
        wait_a(0, "x0_req_wait");
        repeat (2) tick();
        respond_a(32'h5555_AAAA);
        check("x0_no_wb", 68'(a_wb_valid), 68'd0);
        wait_a(2, "x0_idle");

        // Address wrap: 0xFFFFFFFC + 8 = 0x4
        exp_a.push_back(mk(K_REQ, {32'h0000_0004, 32'h0, 1'b1, 3'b010}, '0, '0, '0));
        exp_a.push_back(mk(K_WB, '0, 5'd8, 32'h0BAD_CAFE, '0));
        issue_a(gen_lw_instr(5'd8, 5'd7, 12'h008));
        wait_a(0, "wrap_req_wait");
        repeat (2) tick();
        respond_a(32'h0BAD_CAFE);
        wait_a(2, "wrap_idle");

        // Reset while waiting for a response
        exp_a.push_back(mk(K_REQ, {32'h0000_0200, 32'h0, 1'b1, 3'b010}, '0, '0, '0));
        issue_a(gen_lw_instr(5'd9, 5'd1, 12'h000));
        wait_a(0, "rstw_req_wait");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rstw_busy", 68'(a_busy), 68'd0);
        check("rstw_ready", 68'(ifa.instr_ready), 68'd0);
        check("rstw_req_valid", 68'(ifa.mem_req_valid), 68'd0);
        check("rstw_req", ifa.mem_req, 68'd0);
        check("rstw_wb", 68'({a_wb_valid, a_wb_rd, a_wb_data}), 68'd0);
        check("rstw_err", 68'({a_err_valid, a_err_code}), 68'd0);
        check("rstw_rf_idx", 68'({a_rs1_idx, a_rs2_idx}), 68'd0);
        rst = 1'b0;
        respond_a(32'h7777_8888);
        check("rstw_ready_after", 68'(ifa.instr_ready), 68'd1);
        repeat (2) tick();

        // DUT B: misaligned store issued unchanged
        exp_b.push_back(mk(K_REQ, {32'h0000_0101, 32'hDEAD_BEEF, 1'b0, 3'b010}, '0, '0, '0));
        ifb.instr       = gen_sw_instr(5'd6, 5'd5, 12'h000);
        ifb.instr_valid = 1'b1;
        tick();
        ifb.instr_valid = 1'b0;
        repeat (4) tick();
        check("b_idle", 68'(b_busy), 68'd0);

        repeat (3) tick();
        check("sb_a_empty", 68'(exp_a.size()), 68'd0);
        check("sb_b_empty", 68'(exp_b.size()), 68'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
